rr_mux_arb: RTL and testbench

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/rr_mux_arb.sv | 109 ++++++++++
 tb/tb_rr_mux_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: M-to-1 channel multiplexer feeding a one-word output register.
// Channel choice is a fixed index (MODE 0) or round-robin arbitration (MODE 1).
module rr_mux_arb #(
  parameter int unsigned N    = 32,
  parameter int unsigned M    = 4,
  parameter int unsigned MODE = 1,
  localparam int unsigned SW  = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     in_valid,
  input  logic [M*N-1:0]   in_data,
  output logic [M-1:0]     in_ready,
  input  logic [SW-1:0]    sel,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  logic [N-1:0]  chan [M];

  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic          load_en;
  logic          fix_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_grant;
  logic [SW-1:0] rr_idx;
  logic          grant_vld;
  logic [SW-1:0] grant;

  // (base + step) mod M, for base < M and step < M; also valid for non-power-of-two M.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] base,
                                             input int unsigned   step);
    logic [SW:0] sum;
    sum = {1'b0, base} + (SW+1)'(step);
    if (sum >= (SW+1)'(M)) begin
      sum = sum - (SW+1)'(M);
    end
    return sum[SW-1:0];
  endfunction

  assign load_en = !out_valid_q || out_ready;

  for (genvar g = 0; g < M; g++) begin : g_chan
    assign chan[g]     = in_data[g*N +: N];
    assign in_ready[g] = !rst && load_en && grant_vld && (grant == SW'(g));
  end

  assign fix_vld = ({1'b0, sel} < (SW+1)'(M)) && in_valid[sel];

  always_comb begin
    rr_vld   = 1'b0;
    rr_grant = '0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < M; i++) begin
      rr_idx = wrap_inc(ptr_q, i);
      if (!rr_vld && in_valid[rr_idx]) begin
        rr_vld   = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  assign grant_vld = (MODE == 0) ? fix_vld : rr_vld;
  assign grant     = (MODE == 0) ? sel     : rr_grant;

  // With load_en high the register either takes the granted word or empties;
  // a drain and a load in the same cycle therefore leave no bubble.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = chan[grant];
        out_sel_d  = grant;
        if (MODE != 0) begin
          ptr_d = wrap_inc(grant, 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: one fixed-select and one round-robin instance,
// checked against a reference model with a scoreboard of expected words.
module tb_rr_mux_arb;
  localparam int unsigned N  = 32;
  localparam int unsigned M  = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: MODE 0 instance, index 1: MODE 1 instance.
  logic [M-1:0]   iv   [2];
  logic [M*N-1:0] id   [2];
  logic           ordy [2];
  logic [SW-1:0]  sel0, sel1;
  logic [M-1:0]   ir   [2];
  logic           ov   [2];
  logic [N-1:0]   od   [2];
  logic [SW-1:0]  os   [2];

  rr_mux_arb #(.N(N), .M(M), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
    .sel(sel0), .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(ordy[0])
  );

  rr_mux_arb #(.N(N), .M(M), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
    .sel(sel1), .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(ordy[1])
  );

  int n_checks;
  int n_fail;

  logic           mvalid [2];
  logic [SW-1:0]  mptr   [2];
  logic [N-1:0]   last_d [2];
  logic [SW-1:0]  last_s [2];
  logic [SW+N-1:0] sb0[$];
  logic [SW+N-1:0] sb1[$];
  logic [SW-1:0]  seen_s[$];
  logic [N-1:0]   seen_d[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      mvalid[d] = 1'b0;
      mptr[d]   = '0;
      last_d[d] = '0;
      last_s[d] = '0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Evaluates one cycle of one instance: checks outputs, drains and fills the scoreboard.
  task automatic model_dut(input int d);
    logic            lden, gv;
    logic [SW-1:0]   g;
    logic [M-1:0]    er;
    logic [SW+N-1:0] ent;
    int              sz, gi, c;
    lden = !mvalid[d] || ordy[d];
    gv   = 1'b0;
    g    = '0;
    if (d == 1) begin
      for (int i = 0; i < int'(M); i++) begin
        c = (int'(mptr[1]) + i) % int'(M);
        if (!gv && iv[1][c]) begin
          gv = 1'b1;
          g  = SW'(c);
        end
      end
    end else if (iv[0][sel0]) begin
      gv = 1'b1;
      g  = sel0;
    end
    er = (lden && gv) ? (M'(1) << g) : '0;
    check_eq($sformatf("in_ready%0d", d), 64'(ir[d]), 64'(er));
    check_eq($sformatf("out_valid%0d", d), 64'(ov[d]), 64'(mvalid[d]));
    if (mvalid[d]) begin
      sz = (d == 0) ? sb0.size() : sb1.size();
      check_eq($sformatf("sb_nonempty%0d", d), 64'(sz > 0), 64'(1));
      if (sz > 0) begin
        ent = (d == 0) ? sb0[0] : sb1[0];
        check_eq($sformatf("out_data%0d", d), 64'(od[d]), 64'(ent[N-1:0]));
        check_eq($sformatf("out_sel%0d", d), 64'(os[d]), 64'(ent[SW+N-1:N]));
        if (ordy[d]) begin
          if (d == 0) void'(sb0.pop_front());
          else void'(sb1.pop_front());
          last_d[d] = ent[N-1:0];
          last_s[d] = ent[SW+N-1:N];
          if (d == 1) begin
            seen_s.push_back(os[1]);
            seen_d.push_back(od[1]);
          end
        end
      end
    end else begin
      check_eq($sformatf("hold_data%0d", d), 64'(od[d]), 64'(last_d[d]));
      check_eq($sformatf("hold_sel%0d", d), 64'(os[d]), 64'(last_s[d]));
    end
    if (lden) begin
      mvalid[d] = gv;
      if (gv) begin
        gi  = int'(g);
        ent = {g, id[d][gi*N +: N]};
        if (d == 0) sb0.push_back(ent);
        else sb1.push_back(ent);
        if (d == 1) mptr[1] = SW'((gi + 1) % int'(M));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_dut(0);
    model_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_seen(input string tag, input int n, input logic [SW-1:0] es [5],
                            input logic [N-1:0] ed [5]);
    check_eq({tag, "_len"}, 64'(seen_s.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < seen_s.size()) begin
        check_eq($sformatf("%s_sel%0d", tag, i), 64'(seen_s[i]), 64'(es[i]));
        check_eq($sformatf("%s_data%0d", tag, i), 64'(seen_d[i]), 64'(ed[i]));
      end
    end
    seen_s.delete();
    seen_d.delete();
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_valid%0d", tag, d), 64'(ov[d]), 64'(0));
      check_eq($sformatf("%s_data%0d", tag, d), 64'(od[d]), 64'(0));
      check_eq($sformatf("%s_sel%0d", tag, d), 64'(os[d]), 64'(0));
      check_eq($sformatf("%s_ready%0d", tag, d), 64'(ir[d]), 64'(0));
    end
  endtask

  initial begin
    logic [SW-1:0] es [5];
    logic [N-1:0]  ed [5];
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    sel0 = '0;
    sel1 = '0;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = '0;
      id[d]   = {32'hd, 32'hc, 32'hb, 32'ha};
      ordy[d] = 1'b1;
    end
    reset_model();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin over all four channels with continuous drain.
    iv[1] = 4'b1111;
    repeat (6) tick();
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ed = '{32'ha, 32'hb, 32'hc, 32'hd, 32'ha};
    check_seen("rr_all", 5, es, ed);

    // Pointer at 1 with channels 0 and 3 requesting.
    iv[1] = '0;
    tick();
    seen_s.delete();
    seen_d.delete();
    iv[1] = 4'b0001;
    tick();
    iv[1] = 4'b1001;
    repeat (3) tick();
    iv[1] = '0;
    tick();
    es = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
    ed = '{32'ha, 32'hd, 32'ha, 32'hd, 32'h0};
    check_seen("rr_1001", 4, es, ed);

    // Downstream stall for three cycles.
    iv[1] = 4'b1111;
    tick();
    ordy[1] = 1'b0;
    repeat (3) tick();
    check_eq("stall_ready", 64'(ir[1]), 64'(0));
    check_eq("stall_valid", 64'(ov[1]), 64'(1));
    ordy[1] = 1'b1;
    tick();
    iv[1] = '0;
    repeat (2) tick();
    es = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    ed = '{32'ha, 32'hb, 32'h0, 32'h0, 32'h0};
    check_seen("stall", 2, es, ed);

    // Fixed select on channel 2.
    sel0  = 2'b10;
    iv[0] = 4'b0100;
    #1;
    check_eq("m0_ready", 64'(ir[0]), 64'(4'b0100));
    tick();
    check_eq("m0_valid", 64'(ov[0]), 64'(1));
    check_eq("m0_data", 64'(od[0]), 64'(32'hc));
    check_eq("m0_sel", 64'(os[0]), 64'(2));
    iv[0] = 4'b0011;
    #1;
    check_eq("m0_nogrant_ready", 64'(ir[0]), 64'(0));
    tick();
    check_eq("m0_drop_valid", 64'(ov[0]), 64'(0));
    check_eq("m0_hold_data", 64'(od[0]), 64'(32'hc));
    iv[0] = '0;

    // Asynchronous reset while a word is held.
    iv[1] = 4'b1111;
    tick();
    check_eq("pre_rst_valid", 64'(ov[1]), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    reset_model();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    iv[1] = 4'b1100;
    #1;
    check_eq("post_rst_ready", 64'(ir[1]), 64'(4'b0100));
    tick();
    check_eq("post_rst_sel", 64'(os[1]), 64'(2));
    iv[1] = '0;
    tick();
    seen_s.delete();
    seen_d.delete();

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = M'($urandom_range(0, 15));
        ordy[d] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < int'(M); k++) id[d][k*N +: N] = $urandom();
      end
      sel0 = SW'($urandom_range(0, 3));
      sel1 = SW'($urandom_range(0, 3));
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      iv[d]   = '0;
      ordy[d] = 1'b1;
    end
    repeat (3) tick();
    check_eq("final_sb0", 64'(sb0.size()), 64'(0));
    check_eq("final_sb1", 64'(sb1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
